uart_baud_gen: RTL

Parametrised baud/oversampling tick generator for the UART transmitter and receiver. It replaces fixed compile-time clock division with a runtime-programmable fixed-point divisor, and has a fractional accumulator that cancels long-term baud error. It emits single-cycle sample, mid-bit and bit strobes, and it has a resync input so the receiver can phase-align to a start-bit edge.

---
 rtl/uart_baud_gen.sv | 96 +++++++++
 1 files changed

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: runtime-programmable baud / oversampling tick generator.
// The divisor is unsigned fixed point. Its integer part sets the base sample
// period. Its fraction is accumulated, and each accumulator overflow stretches
// one period by a single cycle, so the long-term mean period is
// I + F/2^FRAC_BITS cycles. A resync pulse restarts the period and the bit
// phase, which lets the receiver align to a start-bit edge.
module uart_baud_gen #(
    parameter int SAMPLING_RATE = 16,
    parameter int DIV_WIDTH     = 16,
    parameter int FRAC_BITS     = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 resync,
    input  logic [DIV_WIDTH+FRAC_BITS-1:0]       divisor,
    output logic                                 sample_tick,
    output logic                                 mid_tick,
    output logic                                 bit_tick,
    output logic [$clog2(SAMPLING_RATE)-1:0]     sample_idx,
    output logic                                 div_err
);

    localparam int IDX_W = $clog2(SAMPLING_RATE);

    logic [DIV_WIDTH-1:0] cnt;
    logic [FRAC_BITS-1:0] acc;

    logic [DIV_WIDTH-1:0] div_int;
    logic [FRAC_BITS-1:0] div_frac;
    logic                 div_low;
    logic [DIV_WIDTH-1:0] int_eff;
    logic [FRAC_BITS-1:0] frac_eff;
    logic [FRAC_BITS:0]   acc_sum;
    logic [DIV_WIDTH-1:0] cnt_resync;
    logic [DIV_WIDTH-1:0] cnt_reload;
    logic [IDX_W-1:0]     idx_next;
    logic                 boundary;

    assign div_int  = divisor[DIV_WIDTH+FRAC_BITS-1:FRAC_BITS];
    assign div_frac = divisor[FRAC_BITS-1:0];
    assign div_low  = (div_int < DIV_WIDTH'(2));

    // Clamp a too-small divisor to the shortest legal period (2 cycles).
    // Sub-cycle fractions are meaningless at that rate, so the fraction is dropped.
    always_comb begin
        int_eff  = div_int;
        frac_eff = div_frac;
        if (div_low) begin
            int_eff  = DIV_WIDTH'(2);
            frac_eff = '0;
        end
    end

    // Reload values. I >= 2 after the clamp, so I-1+carry <= I and always fits in cnt.
    assign acc_sum    = {1'b0, acc} + {1'b0, frac_eff};
    assign cnt_resync = int_eff - DIV_WIDTH'(1);
    assign cnt_reload = int_eff - DIV_WIDTH'(1) + DIV_WIDTH'(acc_sum[FRAC_BITS]);
    assign idx_next   = sample_idx + IDX_W'(1);
    assign boundary   = en && (cnt == '0);

    // Period counter, fractional accumulator, sample index and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            sample_idx  <= '0;
            sample_tick <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
            div_err     <= 1'b0;
        end else begin
            sample_tick <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
            if (resync) begin
                // Resync wins over a coincident boundary and over en=0.
                cnt        <= cnt_resync;
                acc        <= '0;
                sample_idx <= '0;
                div_err    <= div_low;
            end else if (boundary) begin
                cnt         <= cnt_reload;
                acc         <= acc_sum[FRAC_BITS-1:0];
                sample_idx  <= idx_next;
                sample_tick <= 1'b1;
                mid_tick    <= (idx_next == IDX_W'(SAMPLING_RATE / 2));
                bit_tick    <= (idx_next == '0);
                div_err     <= div_low;
            end else if (en) begin
                cnt <= cnt - DIV_WIDTH'(1);
            end
        end
    end

endmodule
